alu_issue_ctrl: RTL and testbench

Multi-cycle initiator for the 5-bit-aluop ALU interface. Accepts one MIPS instruction per valid/ready handshake and decodes opcode/funct into the ALU op code. Fetches register operands, builds extended immediates, drives the ALU for one cycle, captures result/zero and presents a writeback record under a second valid/ready handshake. Sits between fetch/register file and the ALU in the multi-cycle datapath.

---
 rtl/alu_issue_pkg.sv | 96 +++++++++
 rtl/alu_issue_if.sv | 47 ++++
 rtl/alu_issue_dec.sv | 120 ++++++++++++
 rtl/alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller: ALU op codes,
// MIPS opcode/funct encodings, memory-op tags, FSM states and the decode record.
package alu_issue_pkg;

  // ALU operation codes presented on alu_op
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_JALR = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_SLLV = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SRAV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_LUI  = 5'd16;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Memory-op tag carried with the writeback record
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Source of ALU operand B
  typedef enum logic [1:0] {
    IMM_RT   = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_sel_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_e;

  typedef struct packed {
    logic [4:0] op;
    logic [4:0] dest;
    imm_sel_e   imm_sel;
    logic       we;
    logic [1:0] mem_op;
    br_e        br;
    logic       is_jump;
    logic       is_link;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction, register-file, ALU and writeback signals.
// master = issue controller view, slave = surrounding datapath view.
interface alu_issue_if #(
  parameter int PC_W = 30,
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [4:0]      alu_op;
  logic [4:0]      alu_shamt;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [PC_W-1:0] alu_pc;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic [1:0]      mem_op;
  logic            br_taken;
  logic [PC_W-1:0] jr_target;
  logic            illegal;

  modport master (
    input  instr_valid, instr, instr_pc, rs_data, rt_data,
           alu_result, alu_zero, wb_ready,
    output instr_ready, rs_addr, rt_addr, alu_op, alu_shamt, alu_a, alu_b,
           alu_pc, wb_valid, wb_rd, wb_data, wb_we, mem_op, br_taken,
           jr_target, illegal
  );

  modport slave (
    output instr_valid, instr, instr_pc, rs_data, rt_data,
           alu_result, alu_zero, wb_ready,
    input  instr_ready, rs_addr, rt_addr, alu_op, alu_shamt, alu_a, alu_b,
           alu_pc, wb_valid, wb_rd, wb_data, wb_we, mem_op, br_taken,
           jr_target, illegal
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational MIPS decoder: opcode/funct -> ALU op, destination,
// operand-B source, write enable, memory tag, branch kind, illegal flag.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output dec_t       dec
);

  // Decode the instruction fields into the issue record
  always_comb begin
    dec         = '0;
    dec.imm_sel = IMM_RT;
    dec.br      = BR_NONE;
    dec.mem_op  = MEM_NONE;
    dec.dest    = rt;
    dec.we      = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        dec.dest = rd;
        case (funct)
          FN_ADD, FN_ADDU: dec.op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.op = ALU_SUB;
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_XOR:  dec.op = ALU_XOR;
          FN_NOR:  dec.op = ALU_NOR;
          FN_SLT:  dec.op = ALU_SLT;
          FN_SLTU: dec.op = ALU_SLTU;
          FN_SLL:  dec.op = ALU_SLL;
          FN_SRL:  dec.op = ALU_SRL;
          FN_SRA:  dec.op = ALU_SRA;
          FN_SLLV: dec.op = ALU_SLLV;
          FN_SRLV: dec.op = ALU_SRLV;
          FN_SRAV: dec.op = ALU_SRAV;
          FN_JR: begin
            dec.op      = ALU_JR;
            dec.we      = 1'b0;
            dec.is_jump = 1'b1;
          end
          FN_JALR: begin
            dec.op      = ALU_JALR;
            dec.is_jump = 1'b1;
            dec.is_link = 1'b1;
          end
          default: begin
            dec.illegal = 1'b1;
            dec.we      = 1'b0;
          end
        endcase
      end
      OPC_ADDI, OPC_ADDIU: begin
        dec.op      = ALU_ADD;
        dec.imm_sel = IMM_SEXT;
      end
      OPC_SLTI: begin
        dec.op      = ALU_SLT;
        dec.imm_sel = IMM_SEXT;
      end
      OPC_SLTIU: begin
        dec.op      = ALU_SLTU;
        dec.imm_sel = IMM_SEXT;
      end
      OPC_ANDI: begin
        dec.op      = ALU_AND;
        dec.imm_sel = IMM_ZEXT;
      end
      OPC_ORI: begin
        dec.op      = ALU_OR;
        dec.imm_sel = IMM_ZEXT;
      end
      OPC_XORI: begin
        dec.op      = ALU_XOR;
        dec.imm_sel = IMM_ZEXT;
      end
      OPC_LUI: begin
        // the ALU performs the 16-bit left shift itself
        dec.op      = ALU_LUI;
        dec.imm_sel = IMM_ZEXT;
      end
      OPC_LW: begin
        // loaded value is written back by the memory stage, not here
        dec.op      = ALU_ADD;
        dec.imm_sel = IMM_SEXT;
        dec.we      = 1'b0;
        dec.mem_op  = MEM_LOAD;
      end
      OPC_SW: begin
        dec.op      = ALU_ADD;
        dec.imm_sel = IMM_SEXT;
        dec.we      = 1'b0;
        dec.mem_op  = MEM_STORE;
      end
      OPC_BEQ: begin
        dec.op = ALU_SUB;
        dec.we = 1'b0;
        dec.br = BR_EQ;
      end
      OPC_BNE: begin
        dec.op = ALU_SUB;
        dec.we = 1'b0;
        dec.br = BR_NE;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.we      = 1'b0;
      end
    endcase
    // register 0 is hardwired; never request a write to it
    if (dec.dest == 5'd0) begin
      dec.we = 1'b0;
    end else begin
      dec.we = dec.we;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: accepts an instruction, reads operands,
// drives the ALU for one cycle and holds a writeback record until consumed.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int PC_W = 30,
  parameter int XLEN = 32
)(
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.master bus
);

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      ex_op_q, ex_op_d;
  logic [4:0]      ex_dest_q, ex_dest_d;
  logic            ex_we_q, ex_we_d;
  logic [1:0]      ex_mem_q, ex_mem_d;
  br_e             ex_br_q, ex_br_d;
  logic            ex_link_q, ex_link_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      shamt_q, shamt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_we_q, wb_we_d;
  logic [1:0]      mem_op_q, mem_op_d;
  logic            br_taken_q, br_taken_d;
  logic [PC_W-1:0] jr_target_q, jr_target_d;
  logic            illegal_q, illegal_d;

  dec_t            dec_s;
  logic [XLEN-1:0] imm_sext_s;
  logic [XLEN-1:0] imm_zext_s;
  logic [XLEN-1:0] link_s;

  alu_issue_dec u_dec (
    .opcode (instr_q[31:26]),
    .funct  (instr_q[5:0]),
    .rt     (instr_q[20:16]),
    .rd     (instr_q[15:11]),
    .dec    (dec_s)
  );

  assign imm_sext_s = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
  assign imm_zext_s = {{(XLEN-16){1'b0}}, instr_q[15:0]};
  assign link_s     = {{(XLEN-PC_W){1'b0}}, pc_q + {{(PC_W-1){1'b0}}, 1'b1}};

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.rs_addr     = instr_q[25:21];
  assign bus.rt_addr     = instr_q[20:16];
  assign bus.alu_op      = ex_op_q;
  assign bus.alu_shamt   = shamt_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_pc      = pc_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.mem_op      = mem_op_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.jr_target   = jr_target_q;
  assign bus.illegal     = illegal_q;

  // Next-state and datapath register updates for the issue sequence
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    ex_op_d     = ex_op_q;
    ex_dest_d   = ex_dest_q;
    ex_we_d     = ex_we_q;
    ex_mem_d    = ex_mem_q;
    ex_br_d     = ex_br_q;
    ex_link_d   = ex_link_q;
    a_d         = a_q;
    b_d         = b_q;
    shamt_d     = shamt_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    mem_op_d    = mem_op_q;
    br_taken_d  = br_taken_q;
    jr_target_d = jr_target_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          pc_d    = bus.instr_pc;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        ex_op_d   = dec_s.op;
        ex_dest_d = dec_s.dest;
        ex_we_d   = dec_s.we;
        ex_mem_d  = dec_s.mem_op;
        ex_br_d   = dec_s.br;
        ex_link_d = dec_s.is_link;
        a_d       = bus.rs_data;
        shamt_d   = instr_q[10:6];
        case (dec_s.imm_sel)
          IMM_SEXT: b_d = imm_sext_s;
          IMM_ZEXT: b_d = imm_zext_s;
          default:  b_d = bus.rt_data;
        endcase
        if (dec_s.is_jump) begin
          jr_target_d = bus.rs_data[PC_W+1:2];
        end else begin
          jr_target_d = {PC_W{1'b0}};
        end
        if (dec_s.illegal) begin
          // skip the ALU cycle and present an inert record
          wb_valid_d = 1'b1;
          illegal_d  = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = 5'd0;
          wb_data_d  = {XLEN{1'b0}};
          mem_op_d   = MEM_NONE;
          br_taken_d = 1'b0;
          state_d    = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_valid_d = 1'b1;
        illegal_d  = 1'b0;
        wb_we_d    = ex_we_q;
        wb_rd_d    = ex_dest_q;
        mem_op_d   = ex_mem_q;
        if (ex_link_q) begin
          wb_data_d = link_s;
        end else begin
          wb_data_d = bus.alu_result;
        end
        case (ex_br_q)
          BR_EQ:   br_taken_d = bus.alu_zero;
          BR_NE:   br_taken_d = ~bus.alu_zero;
          default: br_taken_d = 1'b0;
        endcase
        state_d = ST_WB;
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= 32'd0;
      pc_q        <= {PC_W{1'b0}};
      ex_op_q     <= 5'd0;
      ex_dest_q   <= 5'd0;
      ex_we_q     <= 1'b0;
      ex_mem_q    <= MEM_NONE;
      ex_br_q     <= BR_NONE;
      ex_link_q   <= 1'b0;
      a_q         <= {XLEN{1'b0}};
      b_q         <= {XLEN{1'b0}};
      shamt_q     <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= {XLEN{1'b0}};
      wb_we_q     <= 1'b0;
      mem_op_q    <= MEM_NONE;
      br_taken_q  <= 1'b0;
      jr_target_q <= {PC_W{1'b0}};
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      ex_op_q     <= ex_op_d;
      ex_dest_q   <= ex_dest_d;
      ex_we_q     <= ex_we_d;
      ex_mem_q    <= ex_mem_d;
      ex_br_q     <= ex_br_d;
      ex_link_q   <= ex_link_d;
      a_q         <= a_d;
      b_q         <= b_d;
      shamt_q     <= shamt_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      mem_op_q    <= mem_op_d;
      br_taken_q  <= br_taken_d;
      jr_target_q <= jr_target_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small register file and ALU model.
module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] rf [32];
  logic [4:0]  ex_op;
  logic [4:0]  ex_sh;
  logic [31:0] ex_b;
  logic [31:0] alu_r;

  alu_issue_if #(.PC_W(30), .XLEN(32)) bus ();

  alu_issue_ctrl #(.PC_W(30), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rs_data  = rf[bus.rs_addr];
  assign bus.rt_data  = rf[bus.rt_addr];
  assign bus.alu_zero = (alu_r == 32'd0);
  assign bus.alu_result = alu_r;

  // Reference ALU behaviour
  always_comb begin
    alu_r = 32'd0;
    case (bus.alu_op)
      5'd0:  alu_r = bus.alu_a + bus.alu_b;
      5'd1:  alu_r = bus.alu_a - bus.alu_b;
      5'd2:  alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      5'd3:  alu_r = bus.alu_a & bus.alu_b;
      5'd4:  alu_r = ~(bus.alu_a | bus.alu_b);
      5'd5:  alu_r = bus.alu_a | bus.alu_b;
      5'd6:  alu_r = bus.alu_a ^ bus.alu_b;
      5'd7:  alu_r = bus.alu_b << bus.alu_shamt;
      5'd8:  alu_r = bus.alu_b >> bus.alu_shamt;
      5'd9:  alu_r = {31'd0, bus.alu_a < bus.alu_b};
      5'd12: alu_r = bus.alu_b << bus.alu_a[4:0];
      5'd13: alu_r = $unsigned($signed(bus.alu_b) >>> bus.alu_shamt);
      5'd14: alu_r = $unsigned($signed(bus.alu_b) >>> bus.alu_a[4:0]);
      5'd15: alu_r = bus.alu_b >> bus.alu_a[4:0];
      5'd16: alu_r = bus.alu_b << 16;
      default: alu_r = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic start(input logic [31:0] ins, input logic [29:0] pc);
    bus.instr       = ins;
    bus.instr_pc    = pc;
    bus.instr_valid = 1'b1;
    check_eq("accept_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // counts edges from accept until wb_valid, snapshotting ALU drive in EXEC
  task automatic wait_wb(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (bus.wb_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        ex_op = bus.alu_op;
        ex_sh = bus.alu_shamt;
        ex_b  = bus.alu_b;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_wb(input string tag);
    bus.wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check_eq({tag, "_wbv_drop"}, 32'(bus.wb_valid), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1]  = 32'd5;
    rf[2]  = 32'd7;
    rf[6]  = 32'h8000_0000;
    rf[7]  = 32'd9;
    rf[8]  = 32'd9;
    rf[11] = 32'h0000_1000;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.instr_pc    = 30'd0;
    bus.wb_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_eq("rst_wb_data", bus.wb_data, 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("rst_alu_op", 32'(bus.alu_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.instr_ready), 32'd1);

    // add $3,$1,$2 : 5 + 7
    start(32'h0022_1820, 30'h10);
    wait_wb("add", 3);
    check_eq("add_op", 32'(ex_op), 32'd0);
    check_eq("add_rd", 32'(bus.wb_rd), 32'd3);
    check_eq("add_data", bus.wb_data, 32'd12);
    check_eq("add_we", 32'(bus.wb_we), 32'd1);
    finish_wb("add");

    // lui $4,0x1234
    start(32'h3C04_1234, 30'h11);
    wait_wb("lui", 3);
    check_eq("lui_op", 32'(ex_op), 32'd16);
    check_eq("lui_b", ex_b, 32'h0000_1234);
    check_eq("lui_data", bus.wb_data, 32'h1234_0000);
    check_eq("lui_rd", 32'(bus.wb_rd), 32'd4);
    finish_wb("lui");

    // sra $5,$6,4
    start(32'h0006_2903, 30'h12);
    wait_wb("sra", 3);
    check_eq("sra_op", 32'(ex_op), 32'd13);
    check_eq("sra_shamt", 32'(ex_sh), 32'd4);
    check_eq("sra_data", bus.wb_data, 32'hF800_0000);
    check_eq("sra_rd", 32'(bus.wb_rd), 32'd5);
    finish_wb("sra");

    // beq $7,$8 with equal operands
    start(32'h10E8_0010, 30'h13);
    wait_wb("beq", 3);
    check_eq("beq_op", 32'(ex_op), 32'd1);
    check_eq("beq_b", ex_b, 32'd9);
    check_eq("beq_taken", 32'(bus.br_taken), 32'd1);
    check_eq("beq_we", 32'(bus.wb_we), 32'd0);
    finish_wb("beq");

    // bne $7,$8 with equal operands
    start(32'h14E8_0010, 30'h14);
    wait_wb("bne", 3);
    check_eq("bne_taken", 32'(bus.br_taken), 32'd0);
    check_eq("bne_we", 32'(bus.wb_we), 32'd0);
    finish_wb("bne");

    // jalr $31,$11 at pc 0x100
    start(32'h0160_F809, 30'h100);
    wait_wb("jalr", 3);
    check_eq("jalr_op", 32'(ex_op), 32'd10);
    check_eq("jalr_data", bus.wb_data, 32'h0000_0101);
    check_eq("jalr_target", 32'(bus.jr_target), 32'h0000_0400);
    check_eq("jalr_rd", 32'(bus.wb_rd), 32'd31);
    check_eq("jalr_we", 32'(bus.wb_we), 32'd1);
    finish_wb("jalr");

    // add $0,$1,$2 : write to r0 suppressed
    start(32'h0022_0020, 30'h15);
    wait_wb("r0", 3);
    check_eq("r0_we", 32'(bus.wb_we), 32'd0);
    finish_wb("r0");

    // sw $2,8($1) : address 13, store tag
    start(32'hAC22_0008, 30'h16);
    wait_wb("sw", 3);
    check_eq("sw_data", bus.wb_data, 32'd13);
    check_eq("sw_mem", 32'(bus.mem_op), 32'd2);
    check_eq("sw_we", 32'(bus.wb_we), 32'd0);
    finish_wb("sw");

    // ori $9,$1,0xF0F0 then stall writeback while addi is offered
    start(32'h3429_F0F0, 30'h17);
    wait_wb("ori", 3);
    check_eq("ori_b", ex_b, 32'h0000_F0F0);
    bus.instr       = 32'h204A_FFFF;
    bus.instr_pc    = 30'h18;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_wbv", 32'(bus.wb_valid), 32'd1);
      check_eq("stall_data", bus.wb_data, 32'h0000_F0F5);
      check_eq("stall_rd", 32'(bus.wb_rd), 32'd9);
      check_eq("stall_rdy", 32'(bus.instr_ready), 32'd0);
    end
    bus.wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check_eq("stall_idle_rdy", 32'(bus.instr_ready), 32'd1);
    check_eq("stall_idle_wbv", 32'(bus.wb_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    wait_wb("addi", 3);
    check_eq("addi_b", ex_b, 32'hFFFF_FFFF);
    check_eq("addi_data", bus.wb_data, 32'd6);
    check_eq("addi_rd", 32'(bus.wb_rd), 32'd10);
    finish_wb("addi");

    // illegal opcode 0x3F
    start(32'hFC00_0000, 30'h19);
    wait_wb("ill", 2);
    check_eq("ill_flag", 32'(bus.illegal), 32'd1);
    check_eq("ill_we", 32'(bus.wb_we), 32'd0);
    finish_wb("ill");

    // reset asserted during EXEC
    start(32'h0022_1820, 30'h1A);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_wbv", 32'(bus.wb_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("postrst_wbv", 32'(bus.wb_valid), 32'd0);
      check_eq("postrst_rdy", 32'(bus.instr_ready), 32'd1);
    end

    // normal operation resumes after reset
    start(32'h0022_1820, 30'h1B);
    wait_wb("add2", 3);
    check_eq("add2_data", bus.wb_data, 32'd12);
    finish_wb("add2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
